addsub_feeder: RTL and testbench

- Operand feeder and result collector wrapped around the 8-bit add/subtract stage (1-cycle registered latency, no valid/handshake of its own).
- Accepts operand commands over a valid/ready channel, buffers them, and drives the stage's dataa/datab/add_sub inputs.
- Tracks in-flight operations and captures each result on the exact cycle it is produced.
- Returns results in order over a valid/ready response channel, with credit-based flow control so no result is ever dropped.

---
 rtl/addsub_pkg.sv | 15 +
 rtl/addsub_sync_fifo.sv | 50 +++++
 rtl/addsub_feeder.sv | 100 ++++++++++
 tb/tb_addsub_feeder.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types for the add/sub operand feeder: operand command and tagged result.
package addsub_pkg;
  localparam int ADDSUB_W = 8;

  typedef struct packed {
    logic [ADDSUB_W-1:0] dataa;
    logic [ADDSUB_W-1:0] datab;
    logic                add_sub;
  } op_t;

  typedef struct packed {
    logic [ADDSUB_W-1:0] result;
    logic                add_sub;
  } res_t;
endpackage

// File: rtl/addsub_sync_fifo.sv
// Synchronous FIFO with registered occupancy count; reset clears storage so the head reads 0.
module addsub_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a full FIFO may still take a write when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) push && !pop |-> !full);
endmodule

// File: rtl/addsub_feeder.sv
// Feeds a 1-cycle add/sub stage from a command FIFO and collects its results in order,
// reserving response-FIFO space for every op before it is issued.
module addsub_feeder
  import addsub_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int W         = ADDSUB_W  // must equal ADDSUB_W (struct field width)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [W-1:0] cmd_dataa,
  input  logic [W-1:0] cmd_datab,
  input  logic         cmd_add_sub,
  output logic [W-1:0] op_dataa,
  output logic [W-1:0] op_datab,
  output logic         op_add_sub,
  output logic         op_fire,
  input  logic [W-1:0] res_in,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic         rsp_add_sub,
  output logic [1:0]   inflight
);
  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);

  op_t            cmd_in, cmd_head;
  res_t           rsp_in, rsp_head;
  logic           cmd_full, cmd_empty, rsp_full, rsp_empty;
  logic [CAW:0]   cmd_count;
  logic [RAW:0]   rsp_count;
  logic           s2_vld, s2_add_sub, issue;
  logic [RAW+1:0] credit_used;

  assign cmd_ready = !rst && !cmd_full;
  assign cmd_in    = {cmd_dataa, cmd_datab, cmd_add_sub};

  addsub_sync_fifo #(.WIDTH($bits(op_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(clk), .rst(rst), .push(cmd_valid && cmd_ready), .wdata(cmd_in),
    .pop(issue), .rdata(cmd_head), .full(cmd_full), .empty(cmd_empty), .count(cmd_count)
  );

  // Ops already in the stage hold a slot in the response FIFO; the registered count
  // is used so a same-cycle pop never grants extra credit.
  assign inflight    = {1'b0, op_fire} + {1'b0, s2_vld};
  assign credit_used = (RAW+2)'(rsp_count) + (RAW+2)'(inflight);
  assign issue       = !cmd_empty && (credit_used < (RAW+2)'(RSP_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      op_dataa   <= '0;
      op_datab   <= '0;
      op_add_sub <= 1'b0;
      op_fire    <= 1'b0;
      s2_vld     <= 1'b0;
      s2_add_sub <= 1'b0;
    end else begin
      op_fire <= issue;
      if (issue) begin
        op_dataa   <= cmd_head.dataa;
        op_datab   <= cmd_head.datab;
        op_add_sub <= cmd_head.add_sub;
      end
      s2_vld     <= op_fire;
      s2_add_sub <= op_add_sub;
    end
  end

  // s2_vld marks the cycle res_in carries the stage's answer for the tagged op
  assign rsp_in = {res_in, s2_add_sub};

  addsub_sync_fifo #(.WIDTH($bits(res_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk(clk), .rst(rst), .push(s2_vld), .wdata(rsp_in),
    .pop(rsp_valid && rsp_ready), .rdata(rsp_head), .full(rsp_full), .empty(rsp_empty),
    .count(rsp_count)
  );

  assign rsp_valid   = !rsp_empty;
  assign rsp_result  = rsp_head.result;
  assign rsp_add_sub = rsp_head.add_sub;

  logic [W-1:0] sum, diff;
  assign sum  = op_dataa + op_datab;
  assign diff = op_dataa - op_datab;

  a_add_result: assert property (@(posedge clk) disable iff (rst)
    op_fire && op_add_sub |=> s2_vld && res_in == $past(sum));
  a_sub_result: assert property (@(posedge clk) disable iff (rst)
    op_fire && !op_add_sub |=> s2_vld && res_in == $past(diff));
  a_rsp_no_ovf: assert property (@(posedge clk) disable iff (rst)
    s2_vld |-> !rsp_full || (rsp_valid && rsp_ready));
  a_inflight:   assert property (@(posedge clk) disable iff (rst) inflight <= 2'd2);
  a_cmd_count:  assert property (@(posedge clk) disable iff (rst) cmd_count <= (CAW+1)'(CMD_DEPTH));
  a_rsp_stable: assert property (@(posedge clk) disable iff (rst)
    rsp_valid && !rsp_ready |=> rsp_valid && $stable(rsp_result) && $stable(rsp_add_sub));
endmodule

// File: tb/tb_addsub_feeder.sv
// Scoreboard bench for addsub_feeder with a behavioural 1-cycle add/sub stage attached.
module tb_addsub_feeder;
  localparam int W = 8;

  logic         clk = 1'b0, rst = 1'b1;
  logic         cmd_valid = 1'b0, cmd_ready, cmd_add_sub = 1'b0;
  logic [W-1:0] cmd_dataa = '0, cmd_datab = '0;
  logic [W-1:0] op_dataa, op_datab, res_in, rsp_result;
  logic         op_add_sub, op_fire, rsp_valid, rsp_add_sub, rsp_ready = 1'b0;
  logic [1:0]   inflight;

  int           total = 0, bad = 0, rcvd = 0;
  logic [W:0]   sbq[$];
  bit           stall = 1'b0;
  logic [W:0]   stall_val;

  addsub_feeder dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dataa(cmd_dataa), .cmd_datab(cmd_datab), .cmd_add_sub(cmd_add_sub),
    .op_dataa(op_dataa), .op_datab(op_datab), .op_add_sub(op_add_sub), .op_fire(op_fire),
    .res_in(res_in), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_add_sub(rsp_add_sub), .inflight(inflight)
  );

  always #5 clk = ~clk;

  // external add/sub stage: one registered cycle, no handshake
  always @(posedge clk) res_in <= op_add_sub ? op_dataa + op_datab : op_dataa - op_datab;

  // One clock: sample handshakes before the edge, keep the scoreboard, land on the negedge.
  task automatic tick(output bit acc);
    logic [W-1:0] r;
    logic [W:0]   e;
    #1;
    acc = cmd_valid && cmd_ready;
    if (acc) begin
      r = cmd_add_sub ? cmd_dataa + cmd_datab : cmd_dataa - cmd_datab;
      sbq.push_back({r, cmd_add_sub});
    end
    if (stall) begin
      total++;
      if ({rsp_valid, rsp_result, rsp_add_sub} !== {1'b1, stall_val}) begin
        bad++; $display("FAIL rsp_stable got=%b/%h exp=1/%h", rsp_valid, {rsp_result, rsp_add_sub}, stall_val);
      end
    end
    if (rsp_valid && rsp_ready) begin
      total++; rcvd++;
      if (sbq.size() == 0) begin
        bad++; $display("FAIL rsp_unexpected got=%h", {rsp_result, rsp_add_sub});
      end else begin
        e = sbq.pop_front();
        if ({rsp_result, rsp_add_sub} !== e) begin
          bad++; $display("FAIL rsp_data got=%h/%b exp=%h/%b", rsp_result, rsp_add_sub, e[W:1], e[0]);
        end
      end
    end
    stall     = rsp_valid && !rsp_ready && !rst;
    stall_val = {rsp_result, rsp_add_sub};
    @(negedge clk);
  endtask

  task automatic test_reset();
    bit a;
    rst = 1'b1;
    tick(a); tick(a);
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=0", cmd_ready); end
    total++; if ({op_fire, op_add_sub, op_dataa, op_datab} !== '0) begin
      bad++; $display("FAIL rst_op got=%b/%b/%h/%h exp=0", op_fire, op_add_sub, op_dataa, op_datab); end
    total++; if ({rsp_valid, rsp_add_sub, rsp_result} !== '0) begin
      bad++; $display("FAIL rst_rsp got=%b/%b/%h exp=0", rsp_valid, rsp_add_sub, rsp_result); end
    total++; if (inflight !== 2'd0) begin bad++; $display("FAIL rst_inflight got=%0d exp=0", inflight); end
    rst = 1'b0;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_add();
    bit a;
    rsp_ready = 1'b1;
    cmd_dataa = 8'd1; cmd_datab = 8'd1; cmd_add_sub = 1'b1; cmd_valid = 1'b1;
    tick(a);
    cmd_valid = 1'b0;
    total++; if (a !== 1'b1) begin bad++; $display("FAIL add_accept got=%b exp=1", a); end
    for (int k = 1; k <= 4; k++) begin
      total++; if (rsp_valid !== (k == 4)) begin
        bad++; $display("FAIL add_latency cycle=%0d rsp_valid got=%b exp=%b", k, rsp_valid, k == 4); end
      if (k == 2) begin
        total++; if (op_fire !== 1'b1) begin bad++; $display("FAIL add_op_fire got=%b exp=1", op_fire); end
      end
      if (k == 4) begin
        total++; if ({rsp_result, rsp_add_sub} !== {8'h02, 1'b1}) begin
          bad++; $display("FAIL add_result got=%h/%b exp=02/1", rsp_result, rsp_add_sub); end
      end
      tick(a);
    end
  endtask

  task automatic test_back_to_back();
    bit a;
    int fires = 0, run = 0, maxrun = 0, rv = 0, rvrun = 0, rvmax = 0, base;
    base = rcvd; rsp_ready = 1'b1;
    cmd_dataa = 8'd1;   cmd_datab = 8'd2;   cmd_add_sub = 1'b0; cmd_valid = 1'b1; tick(a);
    cmd_dataa = 8'd200; cmd_datab = 8'd100; cmd_add_sub = 1'b1; tick(a);
    cmd_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (op_fire) begin fires++; run++; end else run = 0;
      if (rsp_valid) begin rv++; rvrun++; end else rvrun = 0;
      if (run > maxrun) maxrun = run;
      if (rvrun > rvmax) rvmax = rvrun;
      tick(a);
    end
    total++; if (fires != 2 || maxrun != 2) begin
      bad++; $display("FAIL b2b_op_fire got=%0d/%0d exp=2/2", fires, maxrun); end
    total++; if (rv != 2 || rvmax != 2 || rcvd - base != 2) begin
      bad++; $display("FAIL b2b_rsp got=%0d/%0d/%0d exp=2/2/2", rv, rvmax, rcvd - base); end
  endtask

  task automatic test_backpressure();
    bit a;
    int sent = 0, base;
    base = rcvd; rsp_ready = 1'b0;
    for (int k = 0; k < 30; k++) begin
      cmd_valid = (sent < 10);
      cmd_dataa = 8'(17 * sent + 3); cmd_datab = 8'(29 * sent); cmd_add_sub = sent[0];
      tick(a); if (a) sent++;
    end
    total++; if (sent != 8) begin bad++; $display("FAIL bp_accepted got=%0d exp=8", sent); end
    total++; if ({cmd_ready, inflight, op_fire, rsp_valid} !== 5'b0_00_0_1) begin
      bad++; $display("FAIL bp_state got=%b/%0d/%b/%b exp=0/0/0/1", cmd_ready, inflight, op_fire, rsp_valid); end
    total++; if (dut.rsp_count !== 3'd4) begin bad++; $display("FAIL bp_rsp_full got=%0d exp=4", dut.rsp_count); end
    rsp_ready = 1'b1;
    for (int k = 0; k < 60 && (sent < 10 || sbq.size() != 0); k++) begin
      cmd_valid = (sent < 10);
      cmd_dataa = 8'(17 * sent + 3); cmd_datab = 8'(29 * sent); cmd_add_sub = sent[0];
      tick(a); if (a) sent++;
    end
    cmd_valid = 1'b0;
    total++; if (sent != 10 || rcvd - base != 10) begin
      bad++; $display("FAIL bp_drain got=%0d/%0d exp=10/10", sent, rcvd - base); end
  endtask

  task automatic test_random_stream();
    bit a;
    int sent = 0, base;
    base = rcvd;
    for (int k = 0; k < 300 && (sent < 16 || sbq.size() != 0); k++) begin
      cmd_valid = (sent < 16);
      cmd_dataa = 8'(sent); cmd_datab = 8'(sent); cmd_add_sub = 1'b1;
      rsp_ready = 1'($urandom_range(0, 1));
      tick(a); if (a) sent++;
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    total++; if (sent != 16 || rcvd - base != 16) begin
      bad++; $display("FAIL stream_count got=%0d/%0d exp=16/16", sent, rcvd - base); end
  endtask

  task automatic test_reset_mid();
    bit a, hit = 1'b0;
    int base;
    rsp_ready = 1'b0; cmd_valid = 1'b1; cmd_add_sub = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cmd_dataa = 8'(k); cmd_datab = 8'(3 * k); tick(a);
    end
    rsp_ready = 1'b1; tick(a); tick(a);
    rsp_ready = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      if (inflight == 2'd2 && dut.cmd_count == 3'd3) hit = 1'b1;
      else tick(a);
    end
    total++; if (!hit) begin bad++; $display("FAIL rmid_setup got=%0d/%0d exp=2/3", inflight, dut.cmd_count); end
    rst = 1'b1; cmd_valid = 1'b0;
    tick(a);
    rst = 1'b0; sbq.delete(); stall = 1'b0;
    total++; if ({rsp_valid, inflight, op_fire} !== 4'b0) begin
      bad++; $display("FAIL rmid_clear got=%b/%0d/%b exp=0/0/0", rsp_valid, inflight, op_fire); end
    base = rcvd; rsp_ready = 1'b1;
    cmd_dataa = 8'd3; cmd_datab = 8'd1; cmd_add_sub = 1'b0; cmd_valid = 1'b1;
    tick(a);
    cmd_valid = 1'b0;
    total++; if (a !== 1'b1) begin bad++; $display("FAIL rmid_accept got=%b exp=1", a); end
    for (int k = 0; k < 12; k++) tick(a);
    total++; if (rcvd - base != 1 || sbq.size() != 0) begin
      bad++; $display("FAIL rmid_single got=%0d/%0d exp=1/0", rcvd - base, sbq.size()); end
  endtask

  task automatic test_idle_hold();
    bit a;
    int base;
    base = rcvd; rsp_ready = 1'b1;
    cmd_dataa = 8'h5A; cmd_datab = 8'h33; cmd_add_sub = 1'b1; cmd_valid = 1'b1;
    tick(a);
    cmd_valid = 1'b0; cmd_dataa = 8'hFF; cmd_datab = 8'hEE; cmd_add_sub = 1'b0;
    tick(a);
    total++; if ({op_fire, op_dataa, op_datab, op_add_sub} !== {1'b1, 8'h5A, 8'h33, 1'b1}) begin
      bad++; $display("FAIL idle_issue got=%b/%h/%h/%b exp=1/5a/33/1", op_fire, op_dataa, op_datab, op_add_sub); end
    for (int k = 0; k < 5; k++) begin
      tick(a);
      total++; if ({op_fire, op_dataa, op_datab, op_add_sub} !== {1'b0, 8'h5A, 8'h33, 1'b1}) begin
        bad++; $display("FAIL idle_hold cycle=%0d got=%b/%h/%h/%b exp=0/5a/33/1", k, op_fire, op_dataa, op_datab, op_add_sub); end
    end
    total++; if (rcvd - base != 1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL idle_rsp got=%0d/%b exp=1/0", rcvd - base, rsp_valid); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_random_stream();
    test_reset_mid();
    test_idle_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
